// File: rtl/rvfi_commit_serializer.sv
// Commit-group to single-stream serializer for RVFI tracing: buffers up to NRET
// records per cycle and emits them in program order. Optional stall/high-water
// counters are built when RVFI_SERIAL_STALL_CNT_EN is defined.
module rvfi_commit_serializer #(
  parameter  int NRET  = 2,
  parameter  int DW    = 256,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int NIW   = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NRET-1:0]    commit_valid_i,
  input  logic [NRET*DW-1:0] commit_data_i,
  output logic               commit_ready_o,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [DW-1:0]      trace_data_o,
  output logic [63:0]        trace_order_o,
  output logic [63:0]        trace_cycle_o,
  output logic [NIW-1:0]     trace_nret_id_o,
  output logic               overflow_o,
  output logic [CW-1:0]      count_o
`ifdef RVFI_SERIAL_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [CW-1:0]      hiwater_o
`endif
);

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NRET_C  = CW'(NRET);

  logic [DW-1:0]  data_mem_r  [DEPTH];
  logic [63:0]    order_mem_r [DEPTH];
  logic [63:0]    cycle_mem_r [DEPTH];
  logic [NIW-1:0] lane_mem_r  [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [63:0]   order_r;
  logic [63:0]   cycle_r;
  logic          overflow_r;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] pcnt_s;
  logic [CW-1:0] count_next_s;
  logic [CW-1:0] rank_s [NRET];
  logic [AW-1:0] slot_s [NRET];

  // Rank of each valid lane among the valid lanes, and its compacted write slot.
  always_comb begin
    pcnt_s = '0;
    for (int k = 0; k < NRET; k++) begin
      rank_s[k] = pcnt_s;
      slot_s[k] = wr_ptr_r + pcnt_s[AW-1:0];
      if (commit_valid_i[k]) begin
        pcnt_s = pcnt_s + ONE_C;
      end else begin
        pcnt_s = pcnt_s;
      end
    end
  end

  // Ready from registered occupancy only; a same-cycle pop never raises it.
  always_comb begin
    ready_s      = (DEPTH_C - count_r) >= NRET_C;
    push_s       = ready_s && (|commit_valid_i);
    pop_s        = (count_r != '0) && trace_ready_i;
    count_next_s = count_r;
    if (push_s) begin
      count_next_s = count_next_s + pcnt_s;
    end else begin
      count_next_s = count_next_s;
    end
    if (pop_s) begin
      count_next_s = count_next_s - ONE_C;
    end else begin
      count_next_s = count_next_s;
    end
  end

  // Record storage; no reset needed since the outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (!rst_i && push_s && commit_valid_i[k]) begin
        data_mem_r[slot_s[k]]  <= commit_data_i[k*DW +: DW];
        order_mem_r[slot_s[k]] <= order_r + 64'(rank_s[k]);
        cycle_mem_r[slot_s[k]] <= cycle_r;
        lane_mem_r[slot_s[k]]  <= NIW'(k);
      end
    end
  end

  // Pointers, occupancy, order/cycle counters and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      order_r    <= 64'd0;
      cycle_r    <= 64'd0;
      overflow_r <= 1'b0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + pcnt_s[AW-1:0];
        order_r  <= order_r + 64'(pcnt_s);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if ((|commit_valid_i) && !ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head presentation straight from storage, forced to zero while empty.
  always_comb begin
    commit_ready_o = ready_s;
    trace_valid_o  = (count_r != '0);
    overflow_o     = overflow_r;
    count_o        = count_r;
    if (count_r != '0) begin
      trace_data_o    = data_mem_r[rd_ptr_r];
      trace_order_o   = order_mem_r[rd_ptr_r];
      trace_cycle_o   = cycle_mem_r[rd_ptr_r];
      trace_nret_id_o = lane_mem_r[rd_ptr_r];
    end else begin
      trace_data_o    = '0;
      trace_order_o   = 64'd0;
      trace_cycle_o   = 64'd0;
      trace_nret_id_o = '0;
    end
  end

`ifdef RVFI_SERIAL_STALL_CNT_EN
  logic [31:0]   stall_cnt_r;
  logic [CW-1:0] hiwater_r;

  // Saturating backpressure counter and peak occupancy tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
      hiwater_r   <= '0;
    end else begin
      if (trace_valid_o && !trace_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (count_next_s > hiwater_r) begin
        hiwater_r <= count_next_s;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign hiwater_o   = hiwater_r;
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Self-checking bench for rvfi_commit_serializer: a queue scoreboard is filled as
// commit groups are accepted and compared against the head every cycle.
module tb_rvfi_commit_serializer;
  localparam int NRET  = 2;
  localparam int DW    = 256;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NIW   = 1;

  typedef struct {
    logic [DW-1:0]  data;
    logic [63:0]    order;
    logic [63:0]    cyc;
    logic [NIW-1:0] lane;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NRET-1:0]    cv  = '0;
  logic [NRET*DW-1:0] cd  = '0;
  logic               tr  = 1'b0;
  logic               commit_ready, trace_valid, overflow;
  logic [DW-1:0]      trace_data;
  logic [63:0]        trace_order, trace_cycle;
  logic [NIW-1:0]     trace_nret_id;
  logic [CW-1:0]      count;
`ifdef RVFI_SERIAL_STALL_CNT_EN
  logic [31:0]        stall_cnt;
  logic [CW-1:0]      hiwater;
`endif

  rec_t        exp_q[$];
  logic [63:0] m_order = 64'd0;
  logic [63:0] m_cycle = 64'd0;
  bit          m_ovf   = 1'b0;
  bit          chk_en  = 1'b0;
  int          n_cmp   = 0;
  int          n_err   = 0;

  rvfi_commit_serializer #(.NRET(NRET), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_data_i(cd),
    .commit_ready_o(commit_ready), .trace_valid_o(trace_valid), .trace_ready_i(tr),
    .trace_data_o(trace_data), .trace_order_o(trace_order), .trace_cycle_o(trace_cycle),
    .trace_nret_id_o(trace_nret_id), .overflow_o(overflow), .count_o(count)
`ifdef RVFI_SERIAL_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt), .hiwater_o(hiwater)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock edge; the reference model consumes the inputs held across it.
  task automatic step();
    bit   ready_m;
    rec_t r;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_order = 64'd0;
      m_cycle = 64'd0;
      m_ovf   = 1'b0;
    end else begin
      ready_m = (DEPTH - exp_q.size()) >= NRET;
      if (exp_q.size() != 0 && tr) void'(exp_q.pop_front());
      if (|cv) begin
        if (ready_m) begin
          for (int k = 0; k < NRET; k++) begin
            if (cv[k]) begin
              r.data  = cd[k*DW +: DW];
              r.order = m_order;
              r.cyc   = m_cycle;
              r.lane  = NIW'(k);
              exp_q.push_back(r);
              m_order = m_order + 64'd1;
            end
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_cycle = m_cycle + 64'd1;
    end
    #1;
  endtask

  // Scoreboard comparison of every visible output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (trace_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL sb_valid got %b want %b", trace_valid, exp_q.size() != 0);
      end
      n_cmp++;
      if (count !== CW'(exp_q.size())) begin
        n_err++; $display("FAIL sb_count got %0d want %0d", count, exp_q.size());
      end
      n_cmp++;
      if (commit_ready !== ((DEPTH - exp_q.size()) >= NRET)) begin
        n_err++; $display("FAIL sb_ready got %b want %b", commit_ready, (DEPTH - exp_q.size()) >= NRET);
      end
      n_cmp++;
      if (overflow !== m_ovf) begin
        n_err++; $display("FAIL sb_overflow got %b want %b", overflow, m_ovf);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        if (trace_data !== exp_q[0].data || trace_order !== exp_q[0].order ||
            trace_cycle !== exp_q[0].cyc || trace_nret_id !== exp_q[0].lane) begin
          n_err++;
          $display("FAIL sb_head got order %0d cycle %0d id %0d want order %0d cycle %0d id %0d",
                   trace_order, trace_cycle, trace_nret_id, exp_q[0].order, exp_q[0].cyc, exp_q[0].lane);
        end
      end else if (trace_data !== '0 || trace_order !== 64'd0 || trace_cycle !== 64'd0 || trace_nret_id !== '0) begin
        n_err++; $display("FAIL sb_empty_zero got order %0d cycle %0d want zeros", trace_order, trace_cycle);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cv = '0; tr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_en = 1'b1;
    n_cmp++;
    if (count !== '0 || trace_valid !== 1'b0 || overflow !== 1'b0 || commit_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_state got count %0d valid %b ovf %b ready %b want 0 0 0 1",
                        count, trace_valid, overflow, commit_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] a, b;
    do_reset();
    tr = 1'b1;
    repeat (5) step();
    a = rnd(); b = rnd();
    cv = 2'b11; cd = {b, a};
    step();
    cv = '0;
    n_cmp++;
    if (trace_valid !== 1'b1 || trace_data !== a || trace_order !== 64'd0 || trace_cycle !== 64'd5 || trace_nret_id !== 1'b0) begin
      n_err++; $display("FAIL basic_A got valid %b order %0d cycle %0d id %0d want 1 0 5 0",
                        trace_valid, trace_order, trace_cycle, trace_nret_id);
    end
    step();
    n_cmp++;
    if (trace_valid !== 1'b1 || trace_data !== b || trace_order !== 64'd1 || trace_cycle !== 64'd5 || trace_nret_id !== 1'b1) begin
      n_err++; $display("FAIL basic_B got valid %b order %0d cycle %0d id %0d want 1 1 5 1",
                        trace_valid, trace_order, trace_cycle, trace_nret_id);
    end
    step();
    n_cmp++;
    if (trace_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_empty got valid %b want 0", trace_valid);
    end
  endtask

  task automatic test_sparse();
    logic [DW-1:0] c, d;
    do_reset();
    c = rnd(); d = rnd();
    cv = 2'b10; cd = {c, rnd()};
    step();
    cv = 2'b01; cd = {rnd(), d};
    step();
    cv = '0;
    n_cmp++;
    if (trace_data !== c || trace_order !== 64'd0 || trace_nret_id !== 1'b1 || count !== CW'(2)) begin
      n_err++; $display("FAIL sparse_C got order %0d id %0d count %0d want 0 1 2", trace_order, trace_nret_id, count);
    end
    tr = 1'b1;
    step();
    n_cmp++;
    if (trace_data !== d || trace_order !== 64'd1 || trace_nret_id !== 1'b0) begin
      n_err++; $display("FAIL sparse_D got order %0d id %0d want 1 0", trace_order, trace_nret_id);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [63:0] last1, last2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cv = 2'b11; cd = {rnd(), rnd()};
      step();
      n_cmp++;
      if (count !== CW'(2 * (i + 1))) begin
        n_err++; $display("FAIL ovf_fill_count got %0d want %0d", count, 2 * (i + 1));
      end
    end
    n_cmp++;
    if (commit_ready !== 1'b0) begin
      n_err++; $display("FAIL ovf_ready_full got %b want 0", commit_ready);
    end
    step();
    n_cmp++;
    if (count !== CW'(8) || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_fifth got count %0d ovf %b want 8 1", count, overflow);
    end
    cv = '0; tr = 1'b1;
    step();
    n_cmp++;
    if (count !== CW'(7) || commit_ready !== 1'b0) begin
      n_err++; $display("FAIL ovf_free1 got count %0d ready %b want 7 0", count, commit_ready);
    end
    step();
    cv = 2'b11; cd = {rnd(), rnd()};
    step();
    cv = '0;
    last1 = 64'hFFFF_FFFF_FFFF_FFFF; last2 = last1;
    for (int i = 0; i < 20; i++) begin
      if (trace_valid) begin
        last2 = last1; last1 = trace_order;
      end
      step();
    end
    n_cmp++;
    if (last2 !== 64'd8 || last1 !== 64'd9 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_order_resume got %0d,%0d ovf %b want 8,9 1", last2, last1, overflow);
    end
  endtask

  task automatic test_steady();
    logic [DW-1:0] v;
    do_reset();
    tr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = rnd();
      cv = 2'b01; cd = {rnd(), v};
      step();
      n_cmp++;
      if (count !== CW'(1) || trace_order !== 64'(i) || trace_data !== v) begin
        n_err++; $display("FAIL steady got count %0d order %0d want 1 %0d", count, trace_order, i);
      end
    end
    cv = '0;
    step();
    n_cmp++;
    if (trace_valid !== 1'b0) begin
      n_err++; $display("FAIL steady_drain got valid %b want 0", trace_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    do_reset();
    cv = 2'b11; cd = {rnd(), rnd()}; step();
    cv = 2'b11; cd = {rnd(), rnd()}; step();
    cv = 2'b01; cd = {rnd(), rnd()}; step();
    n_cmp++;
    if (count !== CW'(5)) begin
      n_err++; $display("FAIL rstmid_pre got count %0d want 5", count);
    end
    rst = 1'b1; cv = 2'b11;
    step();
    rst = 1'b0;
    n_cmp++;
    if (count !== '0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear got count %0d valid %b ovf %b want 0 0 0", count, trace_valid, overflow);
    end
    e = rnd();
    cv = 2'b01; cd = {rnd(), e};
    step();
    cv = '0;
    n_cmp++;
    if (trace_data !== e || trace_order !== 64'd0 || trace_cycle !== 64'd0) begin
      n_err++; $display("FAIL rstmid_first got order %0d cycle %0d want 0 0", trace_order, trace_cycle);
    end
    tr = 1'b1;
    step();
  endtask

`ifdef RVFI_SERIAL_STALL_CNT_EN
  task automatic test_stall();
    do_reset();
    cv = 2'b11; cd = {rnd(), rnd()};
    step();
    cv = '0;
    repeat (10) step();
    n_cmp++;
    if (stall_cnt !== 32'd10 || hiwater !== CW'(2)) begin
      n_err++; $display("FAIL stall got stall %0d hiwater %0d want 10 2", stall_cnt, hiwater);
    end
    tr = 1'b1;
    repeat (2) step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_overflow();
    test_steady();
    test_reset_mid();
`ifdef RVFI_SERIAL_STALL_CNT_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
